// File: rtl/rr_ic_pkg.sv
// rr_ic_pkg: types and constants shared by the round-robin interconnect blocks
package rr_ic_pkg;
  typedef struct packed {
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        write;
  } packet_t;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_ACK} slv_state_e;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_mem_array.sv
// rr_mem_array: DEPTH x 32 storage, synchronous write, combinational read, no reset
//   clk in; we/waddr/wdata write port; raddr in, rdata out (combinational)
module rr_mem_array #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_comb rdata = mem[raddr];
endmodule

// File: rtl/rr_memory_slave.sv
// rr_memory_slave: single-port word memory serving granted packets with fixed-latency reads
//   clk, reset (sync, active-low), req_valid, mem_req {wdata, addr, write} in;
//   rdata/rdata_ack (one-cycle read completion), busy out;
//   addr_err out only when MEMSLV_RANGE_CHECK_EN is defined.
module rr_memory_slave
  import rr_ic_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  packet_t     mem_req,
  output logic [31:0] rdata,
  output logic        rdata_ack,
`ifdef MEMSLV_RANGE_CHECK_EN
  output logic        addr_err,
`endif
  output logic        busy
);
  slv_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] idx, rd_idx;
  logic [31:0] mem_rdata;
  logic accept, range_err, rd_err, unused;
  assign idx = mem_req.addr[ADDR_W+1:2];
  assign unused = ^{mem_req.addr[1:0], mem_req.addr[31:ADDR_W+2]};
`ifdef MEMSLV_RANGE_CHECK_EN
  assign range_err = |mem_req.addr[31:ADDR_W+2];
`else
  assign range_err = 1'b0;
`endif
  // the ack cycle is IDLE but still carries the held read's grant, so it is not accepted again
  assign accept = reset && state == IDLE && req_valid && !rdata_ack;
  assign busy = state != IDLE;
  rr_mem_array #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk  (clk),
    .we   (accept && mem_req.write && !range_err),
    .waddr(idx),
    .wdata(mem_req.wdata),
    .raddr(rd_idx),
    .rdata(mem_rdata)
  );
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: if (accept && !mem_req.write) begin
        cnt_nxt = 4'(READ_LATENCY - 1);
        state_nxt = READ_LATENCY == 1 ? RD_ACK : RD_WAIT;
      end
      RD_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        state_nxt = cnt == 4'd1 ? RD_ACK : RD_WAIT;
      end
      RD_ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      rdata <= '0;
      rdata_ack <= 1'b0;
      rd_idx <= '0;
      rd_err <= 1'b0;
`ifdef MEMSLV_RANGE_CHECK_EN
      addr_err <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      rdata_ack <= state == RD_ACK;
      rdata <= state == RD_ACK ? (rd_err ? ERR_RDATA : mem_rdata) : '0;
      if (accept && !mem_req.write) begin
        rd_idx <= idx;
        rd_err <= range_err;
      end
`ifdef MEMSLV_RANGE_CHECK_EN
      addr_err <= accept && range_err;
`endif
    end
  end
endmodule

// File: tb/tb_rr_memory_slave.sv
// tb_rr_memory_slave: randomized scoreboard bench for rr_memory_slave at READ_LATENCY 1, 2 and 3
module tb_rr_memory_slave;
  import rr_ic_pkg::*;
  localparam int NI = 3;
`ifdef MEMSLV_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errors = 0, checks = 0, done = 0;
  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int RL = g + 1;
    logic reset = 1'b0, req_valid = 1'b0;
    packet_t mem_req = '0;
    logic [31:0] rdata;
    logic rdata_ack, busy;
`ifdef MEMSLV_RANGE_CHECK_EN
    logic addr_err;
`endif
    rr_memory_slave #(.DEPTH(1024), .ADDR_W(10), .READ_LATENCY(RL)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .mem_req  (mem_req),
      .rdata    (rdata),
      .rdata_ack(rdata_ack),
`ifdef MEMSLV_RANGE_CHECK_EN
      .addr_err (addr_err),
`endif
      .busy     (busy)
    );
    // reference: word array plus "earliest edge a new request may be accepted"
    logic [31:0] model [1024];
    exp_t q[$];
    int next_free = 0, busy_lo = 0, busy_hi = -1, err_due = -1;
    task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      int e, i;
      logic bad;
      req_valid = v;
      mem_req.wdata = d;
      mem_req.addr = a;
      mem_req.write = w;
      @(posedge clk);
      #1;
      e = cyc;
      i = int'(a[11:2]);
      bad = RC && a[31:12] != 20'h0;
      if (!reset) begin
        q.delete();
        busy_hi = -1;
        next_free = e + 1;
      end else if (v && e >= next_free) begin
        if (bad) err_due = e;
        if (w) begin
          if (!bad) model[i] = d;
          next_free = e + 1;
        end else begin
          q.push_back('{bad ? 32'hDEAD_BEEF : model[i], e + RL});
          busy_lo = e;
          busy_hi = e + RL - 1;
          next_free = e + RL + 2;
        end
      end
    endtask
    task automatic rd(input logic [31:0] a);
      step(1'b1, 1'b0, a, 32'h0);
      repeat (RL + 1) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask
    initial begin : mon
      exp_t x;
      int k;
      forever begin
        @(negedge clk);
        k = cyc;
        checks++;
        if (busy !== (k >= busy_lo && k <= busy_hi)) begin
          errors++;
          $display("FAIL busy rl=%0d cyc=%0d got=%b want=%b", RL, k, busy, k >= busy_lo && k <= busy_hi);
        end
`ifdef MEMSLV_RANGE_CHECK_EN
        checks++;
        if (addr_err !== (k == err_due)) begin
          errors++;
          $display("FAIL addr_err rl=%0d cyc=%0d got=%b want=%b", RL, k, addr_err, k == err_due);
        end
`endif
        checks++;
        if (rdata_ack === 1'b1) begin
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious_ack rl=%0d cyc=%0d got ack=1 want ack=0", RL, k);
          end else begin
            x = q.pop_front();
            if (k != x.due) begin
              errors++;
              $display("FAIL ack_time rl=%0d got cyc=%0d want cyc=%0d", RL, k, x.due);
            end
            checks++;
            if (rdata !== x.data) begin
              errors++;
              $display("FAIL rdata rl=%0d cyc=%0d got=%h want=%h", RL, k, rdata, x.data);
            end
          end
        end else begin
          if (rdata !== 32'h0 || rdata_ack !== 1'b0) begin
            errors++;
            $display("FAIL idle_out rl=%0d cyc=%0d got rdata=%h ack=%b want 0/0", RL, k, rdata, rdata_ack);
          end
          if (q.size() != 0 && k > q[0].due) begin
            errors++;
            $display("FAIL missing_ack rl=%0d cyc=%0d got none want ack at cyc=%0d", RL, k, q[0].due);
            void'(q.pop_front());
          end
        end
      end
    end
    initial begin : drv
      logic [31:0] r1, r2;
      repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
        r1 = $urandom;
        step(1'b1, 1'b1, 32'(i * 4), r1);
      end
      step(1'b1, 1'b1, 32'h10, 32'hA5A5_0001);
      rd(32'h10);
      step(1'b1, 1'b1, 32'h0, 32'h1);
      step(1'b1, 1'b1, 32'h4, 32'h2);
      step(1'b1, 1'b1, 32'h8, 32'h3);
      rd(32'h0);
      rd(32'h4);
      rd(32'h8);
      repeat (10) step(1'b1, 1'b0, 32'h20, 32'h0);
      repeat (RL + 2) step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 1'b0, 32'h10, 32'h0);
      reset = 1'b0;
      step(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      repeat (RL + 2) step(1'b0, 1'b0, 32'h0, 32'h0);
      rd(32'h10);
      step(1'b1, 1'b1, 32'h0001_0000, 32'h1234_5678);
      rd(32'h0001_0000);
      rd(32'h0);
      repeat (300) begin
        r1 = $urandom;
        r2 = $urandom;
        step(r1[11:10] != 2'b00, r1[12], {(r1[2:0] == 3'b000) ? r2[31:12] : 20'h0, 6'h0, r1[7:4], r1[9:8]}, r2);
      end
      repeat (RL + 4) step(1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain rl=%0d got %0d pending want 0", RL, q.size());
      end
      done++;
    end
  end
  initial begin
    for (int i = 0; i < 5000 && done < NI; i++) @(posedge clk);
    checks++;
    if (done < NI) begin
      errors++;
      $display("FAIL timeout got done=%0d want %0d", done, NI);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
